// File: rtl/experiment.sv
// experiment: a small spiking network. Four place neurons drive two output neurons.
//   Learning is reward-modulated: it strengthens the weight that fired for the correct half of the track.
//   Latency: an input spike shows on OutVec on the next cycle (OutVec is a register).
//   There is no backpressure. `run` is a level enable, and all network state freezes while it is low.
// Ports:
//   clk               - single clock; every state update happens on its rising edge
//   reset_lfsr_weight - synchronous, active-high; reseeds the LFSR, clears the network, re-enters INIT
//   run               - level enable for network simulation (IDLE <-> RUN)
//   OutVec[1:0]       - registered output-neuron spikes, one bit per action neuron
module experiment #(
  parameter int W_BITS     = 8,
  parameter int V_BITS     = 12,
  parameter int THRESH     = 512,
  parameter int LEAK_SHIFT = 4,
  parameter int RATE       = 128,
  parameter int LR         = 4,
  parameter int EPOCH_LEN  = 64,
  parameter int REFRACT    = 2
) (
  input  logic       clk,
  input  logic       reset_lfsr_weight,
  input  logic       run,
  output logic [1:0] OutVec
);

  localparam int              E_W        = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam int              R_W        = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [V_BITS:0] THRESH_L   = (V_BITS+1)'(THRESH);
  localparam logic [W_BITS:0] LR_L       = (W_BITS+1)'(LR);
  localparam logic [8:0]      RATE_L     = 9'(RATE);
  localparam logic [E_W-1:0]  EPOCH_LAST = E_W'(EPOCH_LEN - 1);
  localparam logic [R_W-1:0]  REFRACT_L  = R_W'(REFRACT);
  localparam logic [R_W-1:0]  REFR_ONE   = R_W'(1);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   in_init, in_run, lfsr_adv;

  logic [15:0]       lfsr, lfsr_nxt;
  logic [2:0]        init_cnt;
  logic [1:0]        pos;
  logic [E_W-1:0]    epoch_cnt;
  // Weight index is {pos, j}: the place neuron selects the pair, and j selects the output neuron.
  logic [W_BITS-1:0] w [8];
  logic [V_BITS-1:0] v [2];
  logic [R_W-1:0]    refr [2];

  logic              in_spike;
  logic [1:0]        fire;
  logic [1:0]        reward;
  logic [W_BITS-1:0] w_cur   [2];
  logic [V_BITS-1:0] v_leak  [2];
  logic [V_BITS:0]   v_sum   [2];
  logic [V_BITS-1:0] v_sat   [2];
  logic [V_BITS-1:0] v_nxt   [2];
  logic [R_W-1:0]    refr_nxt[2];
  logic [W_BITS:0]   w_wide  [2];
  logic [W_BITS:0]   w_up    [2];
  logic [W_BITS:0]   w_dn    [2];
  logic [W_BITS-1:0] w_upd   [2];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset_lfsr_weight) state <= S_INIT;
    else                   state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_cnt == 3'd7) state_nxt = S_IDLE;
      S_IDLE:  if (run)              state_nxt = S_RUN;
      S_RUN:   if (!run)             state_nxt = S_IDLE;
      default:                       state_nxt = S_INIT;
    endcase
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    in_init = 1'b0;
    in_run  = 1'b0;
    case (state)
      S_INIT:  in_init = 1'b1;
      S_RUN:   in_run  = 1'b1;
      default: ;
    endcase
  end

  // The random source only moves while it is consumed. This makes a paused run resume bit-exactly.
  assign lfsr_adv = in_init | in_run;
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Only the place neuron for the current position can fire, so a single compare is enough.
  assign in_spike = in_run && ({1'b0, lfsr[7:0]} < RATE_L);

  // Neuron 0 is the correct action on the first half of the track, and neuron 1 on the second half.
  assign reward[0] = ~pos[1];
  assign reward[1] =  pos[1];

  // ---------------- neuron dynamics and weight update values ----------------
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_cur[j]  = w[{pos, 1'(j)}];
      v_leak[j] = v[j] - (v[j] >> LEAK_SHIFT);
      v_sum[j]  = {1'b0, v_leak[j]} + (in_spike ? (V_BITS+1)'(w_cur[j]) : '0);
      // The sum is less than 2^(V_BITS+1), so any carry into the top bit means overflow.
      v_sat[j]  = v_sum[j][V_BITS] ? '1 : v_sum[j][V_BITS-1:0];

      fire[j]   = in_run && (refr[j] == '0) && ({1'b0, v_sat[j]} >= THRESH_L);

      // A refractory neuron is clamped at rest. A firing neuron resets and starts its refractory period.
      v_nxt[j]    = ((refr[j] != '0) || fire[j]) ? '0 : v_sat[j];
      refr_nxt[j] = (refr[j] != '0) ? (refr[j] - REFR_ONE)
                                     : (fire[j] ? REFRACT_L : '0);

      w_wide[j] = {1'b0, w_cur[j]};
      w_up[j]   = w_wide[j] + LR_L;
      w_dn[j]   = w_wide[j] - LR_L;
      if (reward[j]) w_upd[j] = w_up[j][W_BITS] ? '1 : w_up[j][W_BITS-1:0];
      else           w_upd[j] = (w_wide[j] < LR_L) ? '0 : w_dn[j][W_BITS-1:0];
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset_lfsr_weight) begin
      lfsr      <= LFSR_SEED;
      init_cnt  <= '0;
      pos       <= '0;
      epoch_cnt <= '0;
      OutVec    <= '0;
      for (int j = 0; j < 2; j++) begin
        v[j]    <= '0;
        refr[j] <= '0;
      end
      for (int k = 0; k < 8; k++) w[k] <= '0;
    end else begin
      if (lfsr_adv) lfsr <= lfsr_nxt;

      // INIT seeds one weight per cycle from the LFSR value before it advances.
      // The low 7 bits keep the initial weights in the lower half of the range.
      if (in_init) begin
        w[init_cnt] <= W_BITS'(lfsr[6:0]);
        init_cnt    <= init_cnt + 3'd1;
      end

      // fire is gated by in_run, so OutVec is 0 in INIT and IDLE.
      OutVec <= fire;

      if (in_run) begin
        if (epoch_cnt == EPOCH_LAST) begin
          epoch_cnt <= '0;
          pos       <= pos + 2'd1;
        end else begin
          epoch_cnt <= epoch_cnt + E_W'(1);
        end
        for (int j = 0; j < 2; j++) begin
          v[j]    <= v_nxt[j];
          refr[j] <= refr_nxt[j];
          // The two neurons always touch different weights, so simultaneous spikes never collide.
          if (fire[j]) w[{pos, 1'(j)}] <= w_upd[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_experiment.sv
// tb_experiment: randomized run/reset stimulus checked against a behavioural network model.
//   Two instances run side by side: default parameters, and THRESH=1 for fast learning.
//   Outputs are sampled 1 time unit after each rising edge.
module tb_experiment;

  localparam int RATE      = 128;
  localparam int LR        = 4;
  localparam int REFRACT   = 2;
  localparam int EPOCH_LEN = 64;
  localparam int LEAK_DIV  = 16;
  localparam int V_MAX     = 4095;
  localparam int W_MAX     = 255;
  localparam int SEED      = 'hACE1;
  localparam int PH_INIT   = 0;
  localparam int PH_IDLE   = 1;
  localparam int PH_RUN    = 2;

  logic       clk = 1'b0;
  logic       reset_lfsr_weight = 1'b1;
  logic       run = 1'b0;
  logic [1:0] out0, out1;

  always #5 clk = ~clk;

  experiment dut0 (
    .clk(clk), .reset_lfsr_weight(reset_lfsr_weight), .run(run), .OutVec(out0)
  );

  experiment #(.THRESH(1)) dut1 (
    .clk(clk), .reset_lfsr_weight(reset_lfsr_weight), .run(run), .OutVec(out1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (one copy per instance) ----------------
  int m_thr   [2] = '{512, 1};
  int m_phase [2];
  int m_initk [2];
  int m_lfsr  [2];
  int m_pos   [2];
  int m_ecnt  [2];
  int m_out   [2];
  int m_v     [2][2];
  int m_refr  [2][2];
  int m_w     [2][8];
  int m_w0    [2][8];

  function automatic int lfsr_step(input int l);
    int fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (fb << 15);
  endfunction

  task automatic model_step(input int m);
    int spike, nv, k, good, o;
    if (reset_lfsr_weight) begin
      m_phase[m] = PH_INIT; m_initk[m] = 0; m_lfsr[m] = SEED;
      m_pos[m] = 0; m_ecnt[m] = 0; m_out[m] = 0;
      for (int j = 0; j < 2; j++) begin m_v[m][j] = 0; m_refr[m][j] = 0; end
      for (int i = 0; i < 8; i++) m_w[m][i] = 0;
    end else if (m_phase[m] == PH_INIT) begin
      m_w[m][m_initk[m]]  = m_lfsr[m] % 128;
      m_w0[m][m_initk[m]] = m_lfsr[m] % 128;
      m_lfsr[m] = lfsr_step(m_lfsr[m]);
      m_out[m] = 0;
      if (m_initk[m] == 7) begin m_phase[m] = PH_IDLE; m_initk[m] = 0; end
      else m_initk[m]++;
    end else if (m_phase[m] == PH_IDLE) begin
      m_out[m] = 0;
      if (run) m_phase[m] = PH_RUN;
    end else begin
      spike = ((m_lfsr[m] % 256) < RATE) ? 1 : 0;
      o = 0;
      for (int j = 0; j < 2; j++) begin
        k = m_pos[m] * 2 + j;
        if (m_refr[m][j] > 0) begin
          m_refr[m][j]--;
          m_v[m][j] = 0;
        end else begin
          nv = m_v[m][j] - m_v[m][j] / LEAK_DIV + (spike ? m_w[m][k] : 0);
          if (nv > V_MAX) nv = V_MAX;
          if (nv >= m_thr[m]) begin
            o += (1 << j);
            m_v[m][j] = 0;
            m_refr[m][j] = REFRACT;
            good = (j == 0) ? (m_pos[m] < 2) : (m_pos[m] >= 2);
            if (good) m_w[m][k] = (m_w[m][k] + LR > W_MAX) ? W_MAX : m_w[m][k] + LR;
            else      m_w[m][k] = (m_w[m][k] < LR) ? 0 : m_w[m][k] - LR;
          end else begin
            m_v[m][j] = nv;
          end
        end
      end
      m_out[m] = o;
      if (m_ecnt[m] == EPOCH_LEN - 1) begin m_ecnt[m] = 0; m_pos[m] = (m_pos[m] + 1) % 4; end
      else m_ecnt[m]++;
      m_lfsr[m] = lfsr_step(m_lfsr[m]);
      if (!run) m_phase[m] = PH_IDLE;
    end
  endtask

  task automatic check_state();
    chk("lfsr_d", dut0.lfsr, m_lfsr[0]);
    chk("pos_d",  dut0.pos,  m_pos[0]);
    chk("lfsr_t", dut1.lfsr, m_lfsr[1]);
    chk("pos_t",  dut1.pos,  m_pos[1]);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("v_d[%0d]", j), dut0.v[j], m_v[0][j]);
      chk($sformatf("v_t[%0d]", j), dut1.v[j], m_v[1][j]);
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("w_d[%0d]", k), dut0.w[k], m_w[0][k]);
      chk($sformatf("w_t[%0d]", k), dut1.w[k], m_w[1][k]);
    end
  endtask

  // Recent THRESH=1 pulses; each must be followed by REFRACT silent cycles.
  logic [1:0] p1 = 2'b00, p2 = 2'b00;

  task automatic tick(input bit full);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    chk("out_d", out0, m_out[0]);
    chk("out_t", out1, m_out[1]);
    for (int j = 0; j < 2; j++)
      if (p1[j] | p2[j]) chk($sformatf("refr_quiet[%0d]", j), out1[j], 0);
    p2 = p1;
    p1 = out1;
    if (full || (cyc % 32 == 0)) check_state();
  endtask

  task automatic check_reset_values();
    chk("rst_out_d", out0, 0);
    chk("rst_out_t", out1, 0);
    chk("rst_lfsr", dut0.lfsr, 16'hACE1);
    chk("rst_pos",  dut0.pos, 0);
    for (int j = 0; j < 2; j++) chk("rst_v", dut0.v[j], 0);
    for (int k = 0; k < 8; k++) chk("rst_w", dut0.w[k], 0);
  endtask

  task automatic check_init_weights();
    chk("init_w00", dut0.w[0], 97);
    chk("init_w01", dut0.w[1], 112);
    chk("init_w10", dut0.w[2], 56);
    chk("init_w00_t", dut1.w[0], 97);
  endtask

  initial begin
    int len, r, rw, pw;

    // Reset for one cycle, then stay idle: INIT must run by itself and OutVec stays 0.
    reset_lfsr_weight = 1'b1; run = 1'b0;
    tick(1'b0);
    check_reset_values();
    reset_lfsr_weight = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b0);
    check_state();
    check_init_weights();
    for (int i = 0; i < 6; i++) tick(1'b1);

    // Reset again, and raise run during INIT: RUN must wait for INIT to finish.
    reset_lfsr_weight = 1'b1;
    tick(1'b0);
    reset_lfsr_weight = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);
    run = 1'b1;
    for (int i = 0; i < 300; i++) tick(1'b0);

    // Pause for 10 cycles. All state must hold and OutVec must be 0.
    run = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b1);
    run = 1'b1;
    for (int i = 0; i < 100; i++) tick(1'b0);

    // Random run levels with occasional resets.
    for (int s = 0; s < 60; s++) begin
      r   = $urandom_range(0, 19);
      len = $urandom_range(1, 40);
      if (r == 0) begin
        reset_lfsr_weight = 1'b1;
        len = $urandom_range(1, 3);
      end else begin
        reset_lfsr_weight = 1'b0;
        run = (r > 5);
      end
      for (int i = 0; i < len; i++) tick(1'b0);
    end
    reset_lfsr_weight = 1'b0;

    // Long run: the THRESH=1 network must saturate its weights toward the rewarded action.
    run = 1'b1;
    for (int i = 0; i < 20000; i++) tick(1'b0);
    check_state();
    for (int p = 0; p < 4; p++) begin
      rw = (p < 2) ? p * 2 : p * 2 + 1;
      pw = (p < 2) ? p * 2 + 1 : p * 2;
      chk($sformatf("sat_reward[%0d]", p), dut1.w[rw], (m_w0[1][rw] > 0) ? W_MAX : 0);
      chk($sformatf("sat_punish[%0d]", p), dut1.w[pw], 0);
    end

    // Reset mid-RUN: reset wins over run, and INIT restarts.
    reset_lfsr_weight = 1'b1;
    tick(1'b0);
    check_reset_values();
    reset_lfsr_weight = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b0);
    check_init_weights();
    for (int i = 0; i < 200; i++) tick(1'b0);
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/experiment.md
EXPERIMENT -- requirements
Module: experiment

Interface
REQ-001 SHALL have parameter W_BITS, default 8: synaptic weight width (unsigned).
REQ-002 SHALL have parameter V_BITS, default 12: membrane potential width (unsigned).
REQ-003 SHALL have parameter THRESH, default 512: output-neuron firing threshold.
REQ-004 SHALL have parameter LEAK_SHIFT, default 4: leak = v >> LEAK_SHIFT per RUN cycle.
REQ-005 SHALL have parameter RATE, default 128: input spike fires when lfsr[7:0] < RATE.
REQ-006 SHALL have parameter LR, default 4: learning-rate step.
REQ-007 SHALL have parameter EPOCH_LEN, default 64: RUN cycles per position.
REQ-008 SHALL have parameter REFRACT, default 2: refractory cycles after a spike.
REQ-009 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-010 SHALL have port reset_lfsr_weight, input, 1: the reset; it is synchronous and active-high.
REQ-011 SHALL have port run, input, 1: level enable for network simulation.
REQ-012 SHALL have port OutVec, output, 2: registered output-neuron spikes; bit j is neuron j (action).

Function
REQ-013 SHALL contain a 16-bit LFSR, x^16+x^14+x^13+x^11+1, right-shift form: fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
REQ-014 SHALL advance the LFSR once per cycle in INIT and RUN only, and hold it in IDLE.
REQ-015 SHALL implement FSM states INIT, IDLE, RUN; reset enters INIT.
REQ-016 INIT SHALL last exactly 8 cycles; in cycle k (0..7), weight w[k>>1][k&1] = {1'b0, lfsr[6:0]} taken from the pre-advance LFSR value; INIT then goes to IDLE.
REQ-017 IDLE SHALL go to RUN when run=1; RUN SHALL go to IDLE when run=0; all network state holds in IDLE.
REQ-018 SHALL hold 4 input (place) neurons x 2 output neurons, i.e. 8 weights of W_BITS.
REQ-019 SHALL keep a 2-bit position pos and an epoch counter; in RUN, when the counter equals EPOCH_LEN-1, it clears and pos increments, wrapping from 3 to 0.
REQ-020 In RUN, input neuron i SHALL spike iff i==pos and lfsr[7:0] < RATE; at most one input spikes per cycle.
REQ-021 Each RUN cycle, for each output j not in refractory: v_j <= sat(v_j - (v_j>>LEAK_SHIFT) + (spike ? w[pos][j] : 0)), saturating at 2^V_BITS-1.
REQ-022 If the new v_j >= THRESH: OutVec[j] = 1 on the next cycle for one cycle, v_j = 0, and a refractory count of REFRACT begins; during refractory v_j stays 0 and no spike occurs.
REQ-023 OutVec SHALL be 0 in INIT and IDLE, and in any RUN cycle without a spike; both bits may be 1 together.
REQ-024 Reward for a spike of neuron j SHALL be 1 iff (j==0 and pos<2) or (j==1 and pos>=2).
REQ-025 On a spike of neuron j, in the same cycle as OutVec[j] is registered: w[pos][j] += LR if reward (saturate at 2^W_BITS-1), else -= LR (saturate at 0).
REQ-026 On simultaneous spikes, both weights SHALL update independently; pos uses the value before the epoch increment of that cycle.

Reset
REQ-027 When reset_lfsr_weight=1 at a clock edge: lfsr=16'hACE1, state=INIT, INIT counter=0, pos=0, epoch counter=0, v_j=0, refractory=0, OutVec=2'b00, all weights=0.
REQ-028 Reset SHALL take priority over run in any state, including mid-INIT and mid-RUN.

Verification
REQ-029 Reset 1 cycle, then run=0 -> OutVec=00 throughout; after INIT, lfsr holds 8 steps past 16'hACE1; w[0][0]=97, w[0][1]=112, w[1][0]=56 (lfsr sequence ACE1, 5670, AB38, ...).
REQ-030 Reset, then run=1 after 5 cycles -> RUN starts only after the 8 INIT cycles; pos advances every 64 RUN cycles and wraps 3->0.
REQ-031 With THRESH=1 and run=1 -> OutVec[j] pulses 1 cycle after each input spike with w[pos][j]>0, followed by exactly REFRACT cycles of silence.
REQ-032 Long RUN (e.g. 20000 cycles) -> at pos 0/1, w[pos][0] rises and w[pos][1] falls, saturating at 255/0; at pos 2/3 the reverse; no weight wraps.
REQ-033 Drop run mid-RUN for 10 cycles -> lfsr, pos, v and weights are unchanged and OutVec=00; resuming continues from the held state.
REQ-034 Assert reset mid-RUN -> next cycle all REQ-027 values hold and INIT restarts.
